term_screen_buffer: RTL

//   Consumes the received-character stream (char + 1-cycle en strobe) from the UART receive

---
 rtl/term_pkg.sv | 33 +++
 rtl/term_char_fifo.sv | 79 +++++++
 rtl/term_screen_buffer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : term_pkg
//  Description : Shared constants, state encoding and helpers for the
//                terminal character screen buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package term_pkg;

    // Default screen geometry
    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    // Character codes of interest
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_MIN   = 8'h20;
    localparam logic [7:0] ASCII_MAX   = 8'h7E;

    // Screen controller states
    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        CLR_ROW = 2'd2
    } term_state_e;

    // True for codes the terminal acts on: printable ASCII or carriage return
    function automatic logic is_accepted(input logic [7:0] code);
        return ((code >= ASCII_MIN) && (code <= ASCII_MAX)) || (code == ASCII_CR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/term_char_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : term_char_fifo
//  Description : Small synchronous FIFO for received characters. Push is
//                ignored when full, pop is ignored when empty. The head entry
//                is presented combinationally on pop_data_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module term_char_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/term_screen_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : term_screen_buffer
//  Description : Terminal character screen memory with cursor handling,
//                autowrap, row clearing and an independent registered read
//                port for the text renderer.
//                Build option TERM_SCROLL_EN: newline on the last row scrolls
//                the screen up one line (row_base rotation); without it the
//                cursor wraps to the top row.
//  Revision    : 1.0 - initial release
// ============================================================================
module term_screen_buffer
    import term_pkg::*;
#(
    parameter int  COLS       = DEFAULT_COLS,
    parameter int  ROWS       = DEFAULT_ROWS,
    parameter int  FIFO_DEPTH = 4,
    localparam int COL_W      = $clog2(COLS),
    localparam int ROW_W      = $clog2(ROWS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [7:0]       char_i,
    input  logic             en_i,
    input  logic [COL_W-1:0] rd_col_i,
    input  logic [ROW_W-1:0] rd_row_i,
    output logic [7:0]       rd_data_o,
    output logic [COL_W-1:0] cursor_col_o,
    output logic [ROW_W-1:0] cursor_row_o,
    output logic             busy_o,
    output logic             overflow_o
);

    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ROW_W1 = ROW_W + 1;

    // (row + base) mod ROWS, both operands already below ROWS
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] row,
                                                  input logic [ROW_W-1:0] base);
        logic [ROW_W:0] sum;
        sum = {1'b0, row} + {1'b0, base};
        if (sum >= ROW_W1'(ROWS)) begin
            sum = sum - ROW_W1'(ROWS);
        end
        return sum[ROW_W-1:0];
    endfunction

    // Linear RAM address of a physical row / column pair
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    // ------------------------------------------------------------------------
    // Input capture and FIFO
    // ------------------------------------------------------------------------
    logic [7:0]        in_char_q;
    logic              in_vld_q;
    logic              in_ok;
    logic              fifo_push;
    logic              fifo_pop;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic              overflow_q, overflow_d;

    // Register the strobe so the FIFO sees a clean, edge-aligned push
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            in_char_q <= '0;
            in_vld_q  <= 1'b0;
        end else begin
            in_char_q <= char_i;
            in_vld_q  <= en_i;
        end
    end

    // Unsupported codes never enter the FIFO; the full test uses the
    // pre-pop occupancy so a simultaneous pop does not rescue the char
    assign in_ok      = in_vld_q && is_accepted(in_char_q);
    assign fifo_push  = in_ok && (fifo_count < FCNT_W'(FIFO_DEPTH));
    assign overflow_d = overflow_q | (in_ok && fifo_full);

    term_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (fifo_push),
        .push_data_i (in_char_q),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // ------------------------------------------------------------------------
    // Screen controller
    // ------------------------------------------------------------------------
    term_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [COL_W-1:0]  clr_col_q, clr_col_d;
    logic [COL_W-1:0]  cursor_col_q, cursor_col_d;
    logic [ROW_W-1:0]  cursor_row_q, cursor_row_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              newline;
    logic [ROW_W-1:0]  nl_prow;

`ifdef TERM_SCROLL_EN
    logic [ROW_W-1:0]  row_base_q, row_base_d;

    // Logical-to-physical row offset, advanced by one on every scroll
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            row_base_q <= '0;
        end else begin
            row_base_q <= row_base_d;
        end
    end
`else
    logic [ROW_W-1:0]  row_base_q;
    assign row_base_q = '0;
`endif

    // Next-state, cursor and RAM write control
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        clr_col_d    = clr_col_q;
        cursor_col_d = cursor_col_q;
        cursor_row_d = cursor_row_q;
`ifdef TERM_SCROLL_EN
        row_base_d   = row_base_q;
`endif
        wr_en        = 1'b0;
        wr_addr      = clr_idx_q;
        wr_data      = ASCII_SPACE;
        fifo_pop     = 1'b0;
        newline      = 1'b0;
        nl_prow      = '0;

        case (state_q)
            CLR_ALL: begin
                wr_en = 1'b1;
                if (clr_idx_q == ADDR_W'(CELLS - 1)) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_head == ASCII_CR) begin
                        newline = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = cell_addr(phys_row(cursor_row_q, row_base_q), cursor_col_q);
                        wr_data = fifo_head;
                        // A char in the last column wraps instead of advancing
                        if (cursor_col_q == COL_W'(COLS - 1)) begin
                            newline = 1'b1;
                        end else begin
                            cursor_col_d = cursor_col_q + COL_W'(1);
                        end
                    end
                end
            end
            CLR_ROW: begin
                wr_en = 1'b1;
                if (clr_col_q == COL_W'(COLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                    clr_col_d = clr_col_q + COL_W'(1);
                end
            end
            default: begin
                state_d = CLR_ALL;
            end
        endcase

        if (newline) begin
            cursor_col_d = '0;
            if (cursor_row_q != ROW_W'(ROWS - 1)) begin
                cursor_row_d = cursor_row_q + ROW_W'(1);
                nl_prow      = phys_row(cursor_row_d, row_base_q);
            end else begin
`ifdef TERM_SCROLL_EN
                // Old top physical row becomes the new (blank) bottom line
                row_base_d = phys_row(ROW_W'(1), row_base_q);
                nl_prow    = row_base_q;
`else
                cursor_row_d = '0;
                nl_prow      = '0;
`endif
            end
            state_d   = CLR_ROW;
            clr_col_d = '0;
            clr_idx_d = cell_addr(nl_prow, COL_W'(0));
        end
    end

    // Controller state, cursor and sticky overflow registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= CLR_ALL;
            clr_idx_q    <= '0;
            clr_col_q    <= '0;
            cursor_col_q <= '0;
            cursor_row_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            clr_col_q    <= clr_col_d;
            cursor_col_q <= cursor_col_d;
            cursor_row_q <= cursor_row_d;
            overflow_q   <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Screen RAM: simple dual-port, one write port, one registered read port
    // ------------------------------------------------------------------------
    logic [7:0]        screen_mem_q [CELLS];
    logic [7:0]        rd_data_q;
    logic [ADDR_W-1:0] rd_addr;

    assign rd_addr = cell_addr(phys_row(rd_row_i, row_base_q), rd_col_i);

    // Write port driven by the controller
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            screen_mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-cell collision returns the old contents
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= screen_mem_q[rd_addr];
        end
    end

    assign rd_data_o    = rd_data_q;
    assign cursor_col_o = cursor_col_q;
    assign cursor_row_o = cursor_row_q;
    assign busy_o       = (state_q != IDLE);
    assign overflow_o   = overflow_q;

endmodule
`default_nettype wire
